// File: rtl/datapath_mem_responder_if.sv
// Datapath-side and RAM-side signal bundle for datapath_mem_responder.
// The slave modport is the responder's view; master is the driver's view.
interface datapath_mem_responder_if #(
    parameter int CNT_W = 16
);
    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             dmemREN;
    logic             dmemWEN;
    logic [31:0]      dmemaddr;
    logic [31:0]      dmemstore;
    logic             halt;
    logic             ihit;
    logic [31:0]      imemload;
    logic             dhit;
    logic [31:0]      dmemload;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic             ramready;
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] dcnt;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN,
        input  dmemaddr, dmemstore, halt,
        input  ramload, ramready,
        output ihit, imemload, dhit, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore,
        output icnt, dcnt
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN,
        output dmemaddr, dmemstore, halt,
        output ramload, ramready,
        input  ihit, imemload, dhit, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  icnt, dcnt
    );
endinterface

// File: rtl/datapath_mem_responder.sv
// Arbitrates datapath instruction/data requests onto a single RAM port,
// data first, with halt handling and saturating access counters.
module datapath_mem_responder #(
    parameter int CNT_W = 16
) (
    input logic                     CLK,
    input logic                     RST,
    datapath_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        HALTED
    } state_t;

    state_t           r_state;
    logic             r_wr;
    logic             r_halt_pend;
    logic             r_ramren;
    logic             r_ramwen;
    logic [31:0]      r_addr;
    logic [31:0]      r_store;
    logic [CNT_W-1:0] r_icnt;
    logic [CNT_W-1:0] r_dcnt;

    logic w_dreq;
    logic w_ihit;
    logic w_dhit;
    logic w_halt_now;

    assign w_dreq     = bus.dmemREN | bus.dmemWEN;
    assign w_ihit     = (r_state == IACC) & bus.ramready;
    assign w_dhit     = (r_state == DACC) & bus.ramready;
    assign w_halt_now = bus.halt | r_halt_pend;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_wr        <= 1'b0;
            r_halt_pend <= 1'b0;
            r_ramren    <= 1'b0;
            r_ramwen    <= 1'b0;
            r_addr      <= '0;
            r_store     <= '0;
            r_icnt      <= '0;
            r_dcnt      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.halt) begin
                        r_state <= HALTED;
                    end else if (w_dreq) begin
                        // write wins when both read and write are asserted
                        r_state  <= DACC;
                        r_wr     <= bus.dmemWEN;
                        r_addr   <= {bus.dmemaddr[31:2], 2'b00};
                        r_store  <= bus.dmemstore;
                        r_ramren <= ~bus.dmemWEN;
                        r_ramwen <= bus.dmemWEN;
                    end else if (bus.imemREN) begin
                        r_state  <= IACC;
                        r_wr     <= 1'b0;
                        r_addr   <= {bus.imemaddr[31:2], 2'b00};
                        r_store  <= bus.dmemstore;
                        r_ramren <= 1'b1;
                        r_ramwen <= 1'b0;
                    end
                end
                DACC, IACC: begin
                    if (bus.halt) begin
                        r_halt_pend <= 1'b1;
                    end
                    if (bus.ramready) begin
                        r_ramren    <= 1'b0;
                        r_ramwen    <= 1'b0;
                        r_halt_pend <= 1'b0;
                        r_state     <= w_halt_now ? HALTED : IDLE;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_ihit && (r_icnt != '1)) begin
                r_icnt <= r_icnt + CNT_W'(1);
            end
            if (w_dhit && (r_dcnt != '1)) begin
                r_dcnt <= r_dcnt + CNT_W'(1);
            end
        end
    end

    assign bus.ihit     = w_ihit;
    assign bus.dhit     = w_dhit;
    assign bus.imemload = w_ihit ? bus.ramload : '0;
    assign bus.dmemload = (w_dhit && !r_wr) ? bus.ramload : '0;
    assign bus.ramREN   = r_ramren;
    assign bus.ramWEN   = r_ramwen;
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;
    assign bus.icnt     = r_icnt;
    assign bus.dcnt     = r_dcnt;
endmodule
